cpu_boot_ctrl: RTL and testbench
================================

# cpu_boot_ctrl

Synthesizable boot and run controller placed between the test/host side and the MIPS CPU. It takes over what the simulation bench does with hierarchical pokes and `$readmemh`: it holds the CPU in reset, initializes the register file, and streams a program image into instruction/data memory through a valid/ready port. It then releases the CPU and, optionally, stops it after a fixed cycle budget. The block is parametrised in data width, memory depth, register count and register-init mode.

## Interface
- DATA_WIDTH, 32, width of memory words and register values
- ADDR_WIDTH, 8, log2 of memory depth in words
- REG_COUNT, 32, number of register-file entries to initialise
- REG_INIT_MODE, 1, 0: all registers 0; 1: register i gets value i
- RUN_CYCLES, 10, CPU clock cycles allowed in RUN (used only with the watchdog)
- clock  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-low; 0 forces the reset state immediately
- start  in  1  pulse; starts a boot sequence from IDLE or DONE
- load_valid  in  1  program word available
- load_ready  out  1  block accepts a word this cycle
- load_data  in  DATA_WIDTH  program word
- load_last  in  1  accompanies the final program word
- mem_we  out  1  memory write strobe
- mem_addr  out  ADDR_WIDTH+2  byte address (word index << 2)
- mem_wdata  out  DATA_WIDTH  memory write data
- rf_we  out  1  register-file write strobe
- rf_addr  out  clog2(REG_COUNT)  register index
- rf_wdata  out  DATA_WIDTH  register write data
- cpu_reset  out  1  active-low reset to CPU
- busy  out  1  high in REG_INIT, LOAD, RUN
- done  out  1  high in DONE
- overflow  out  1  sticky; image exceeded memory depth
- cycle_count  out  32  cycles spent in RUN

## Operation
- States: IDLE -> REG_INIT -> LOAD -> RUN -> DONE. `start` in IDLE or DONE goes to REG_INIT. `start` in any other state is ignored.
- REG_INIT: one write per cycle with rf_addr 0..REG_COUNT-1. rf_wdata = 0 when mode is 0 or the index is 0; otherwise it is the index, zero-extended. After the last index the state moves to LOAD.
- Entering REG_INIT clears overflow, cycle_count and the word index.
- LOAD: load_ready = 1. A word is accepted when load_valid && load_ready. Each accepted word is written at the current index, then the index increments.
- When a word is accepted with load_last = 1, the state moves to RUN after that word's write has been issued.
- Overflow: a word accepted when the index has already wrapped past 2^ADDR_WIDTH-1 is dropped with no write. overflow is set and the state moves directly to DONE, and the CPU is never released.
- RUN: cpu_reset = 1. cycle_count increments every cycle and saturates at 2^32-1.
- DONE: cpu_reset = 0. The state is held until the next `start`.
- cpu_reset is 0 in every state except RUN.

## Timing
- Reset values: state IDLE; load_ready, mem_we, rf_we, busy, done, overflow, cpu_reset = 0; all addresses, data and cycle_count = 0.
- All outputs are registered; none are combinational from inputs.
- start sampled at edge N: the first rf_we occurs in cycle N+1. REG_INIT lasts exactly REG_COUNT cycles.
- A word accepted at edge N appears on mem_we/mem_addr/mem_wdata in cycle N+1. Back-to-back accepts give one write per cycle.
- The last word accepted at edge N: its write appears in cycle N+1, and cpu_reset rises in cycle N+2 (first RUN cycle).
- The first RUN cycle has cycle_count = 0.
- Reset asserted mid-sequence: all outputs return to reset values asynchronously, and the CPU is held in reset.

## Configuration
- BOOT_WATCHDOG_EN defined: when cycle_count reaches RUN_CYCLES-1, the next edge moves to DONE, so exactly RUN_CYCLES run cycles occur.
- BOOT_WATCHDOG_EN undefined: RUN has no exit except reset, and the RUN_CYCLES parameter is ignored.

## Structure
- Package boot_pkg: the state enum, default widths, and a function computing the reset-time register init value.
- One sub-module, boot_counter: a parametrised up-counter with clear, enable, terminal-count flag and optional saturation. It is instantiated three times: register index, word index, and run cycles.

## Test plan
- Reset low then high, no start -> all outputs 0, state IDLE, cpu_reset 0.
- Default parameters, start pulse -> 32 rf_we cycles, with rf_addr 5 carrying rf_wdata 5 and rf_addr 0 carrying 0. With mode 0, every rf_wdata is 0.
- Stream 0x00000000, 0x20100009, then 0x0 with last -> writes at mem_addr 0x0, 0x4, 0x8. cpu_reset rises two cycles after the last accept.
- BOOT_WATCHDOG_EN, RUN_CYCLES=10 -> cpu_reset high for exactly 10 cycles, then done = 1 and cycle_count = 9.
- ADDR_WIDTH=2, stream 5 words -> 4 writes, overflow = 1, done = 1, cpu_reset never high.
- Reset pulled low during LOAD -> outputs clear immediately. A new start restarts at REG_INIT with cleared counters.

Source files
------------

// File: rtl/boot_pkg.sv
// Shared types and helpers for the CPU boot/run controller.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
// Contents: boot_state_t FSM encoding, default widths, reg_init_val().
package boot_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ADDR_WIDTH = 8;
  localparam int DEF_REG_COUNT  = 32;
  localparam int INIT_VAL_WIDTH = 32;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_REG_INIT = 3'd1,
    ST_LOAD     = 3'd2,
    ST_RUN      = 3'd3,
    ST_DONE     = 3'd4
  } boot_state_t;

  // Value written into register idx while initialising the register file.
  // Mode 0 clears everything; mode 1 loads the index, except that r0 stays 0.
  function automatic logic [INIT_VAL_WIDTH-1:0] reg_init_val(input int mode,
                                                             input int unsigned idx);
    if (mode == 0 || idx == 0) return '0;
    return INIT_VAL_WIDTH'(idx);
  endfunction

endpackage

// File: rtl/boot_counter.sv
// Up-counter with synchronous clear, enable, terminal-count flag, optional saturation.
// Latency: count updates one edge after clear/en; tc is a decode of the count register.
// Backpressure: none; the caller gates en.
// Ports: clock, reset (async active-low), clear, en -> count[WIDTH], tc (count == TC_VALUE).
module boot_counter #(
  parameter int               WIDTH    = 8,
  parameter logic [WIDTH-1:0] TC_VALUE = '1,
  parameter bit               SATURATE = 1'b0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             en,
  output logic [WIDTH-1:0] count,
  output logic             tc
);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (en && !(SATURATE && (count == '1))) begin
      count <= count + WIDTH'(1);
    end
  end

  assign tc = (count == TC_VALUE);

endmodule

// File: rtl/cpu_boot_ctrl.sv
// Boot/run controller: holds the CPU in reset, initialises the register file,
//   streams a program image into memory, then releases the CPU.
// Latency: start -> first rf write 1 cycle; accepted word -> memory write 1 cycle;
//   last word -> cpu_reset release 2 cycles after its accept.
// Backpressure: load_ready high only in LOAD until the last word is taken.
// Ports: clock, reset (async active-low), start; load_valid/load_ready/load_data/load_last;
//   mem_we/mem_addr/mem_wdata; rf_we/rf_addr/rf_wdata; cpu_reset, busy, done, overflow, cycle_count.
// Option: define BOOT_WATCHDOG_EN to leave RUN for DONE after RUN_CYCLES cycles.
module cpu_boot_ctrl
  import boot_pkg::*;
#(
  parameter int  DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int  ADDR_WIDTH    = DEF_ADDR_WIDTH,
  parameter int  REG_COUNT     = DEF_REG_COUNT,
  parameter int  REG_INIT_MODE = 1,
  parameter int  RUN_CYCLES    = 10,
  localparam int RW            = (REG_COUNT > 1) ? $clog2(REG_COUNT) : 1,
  localparam int MAW           = ADDR_WIDTH + 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  load_valid,
  output logic                  load_ready,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic                  load_last,
  output logic                  mem_we,
  output logic [MAW-1:0]        mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  rf_we,
  output logic [RW-1:0]         rf_addr,
  output logic [DATA_WIDTH-1:0] rf_wdata,
  output logic                  cpu_reset,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow,
  output logic [31:0]           cycle_count
);

`ifdef BOOT_WATCHDOG_EN
  localparam bit WDOG_EN = 1'b1;
`else
  localparam bit WDOG_EN = 1'b0;
`endif

  boot_state_t         state, state_nxt;
  logic                start_go;
  logic                accept;
  logic                reg_en, reg_tc;
  logic                word_en, wrapped;
  logic                run_en, run_tc, run_exit;
  logic [ADDR_WIDTH:0] word_idx;

  // start is only honoured when no sequence is in flight.
  assign start_go = start && ((state == ST_IDLE) || (state == ST_DONE));
  // load_ready is a registered output, so the handshake never depends
  // combinationally on load_valid.
  assign accept   = (state == ST_LOAD) && load_ready && load_valid;
  assign run_exit = WDOG_EN && (state == ST_RUN) && run_tc;

  assign reg_en   = (state == ST_REG_INIT) && !reg_tc;
  assign word_en  = accept && !wrapped;
  assign run_en   = (state == ST_RUN) && !run_exit;

  // Register index drives rf_addr directly; it holds at the last index.
  boot_counter #(
    .WIDTH    (RW),
    .TC_VALUE (RW'(REG_COUNT - 1)),
    .SATURATE (1'b0)
  ) u_reg_idx (
    .clock (clock),
    .reset (reset),
    .clear (start_go),
    .en    (reg_en),
    .count (rf_addr),
    .tc    (reg_tc)
  );

  // One spare MSB: tc marks that the index has run past the last memory word.
  boot_counter #(
    .WIDTH    (ADDR_WIDTH + 1),
    .TC_VALUE ({1'b1, {ADDR_WIDTH{1'b0}}}),
    .SATURATE (1'b0)
  ) u_word_idx (
    .clock (clock),
    .reset (reset),
    .clear (start_go),
    .en    (word_en),
    .count (word_idx),
    .tc    (wrapped)
  );

  // Run-cycle counter; holds on the exit edge so DONE shows the last RUN count.
  boot_counter #(
    .WIDTH    (32),
    .TC_VALUE (32'(RUN_CYCLES - 1)),
    .SATURATE (1'b1)
  ) u_run_cnt (
    .clock (clock),
    .reset (reset),
    .clear (start_go),
    .en    (run_en),
    .count (cycle_count),
    .tc    (run_tc)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE, ST_DONE: if (start) state_nxt = ST_REG_INIT;
      ST_REG_INIT:      if (reg_tc) state_nxt = ST_LOAD;
      ST_LOAD: begin
        if (accept && wrapped) state_nxt = ST_DONE;
        // load_ready drops once the last word is taken; the following
        // cycle carries that word's write, then RUN begins.
        else if (!load_ready)  state_nxt = ST_RUN;
      end
      ST_RUN:           if (run_exit) state_nxt = ST_DONE;
      default:          state_nxt = ST_IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they change on the
  // same edge as the state register and never glitch.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      load_ready <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      rf_we      <= 1'b0;
      rf_wdata   <= '0;
      cpu_reset  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      mem_we     <= 1'b0;
      rf_we      <= (state_nxt == ST_REG_INIT);
      load_ready <= (state_nxt == ST_LOAD) && !(accept && load_last);
      busy       <= state_nxt inside {ST_REG_INIT, ST_LOAD, ST_RUN};
      done       <= (state_nxt == ST_DONE);
      cpu_reset  <= (state_nxt == ST_RUN);

      // rf_wdata tracks the value for the index the counter will hold next.
      if (start_go) begin
        overflow <= 1'b0;
        rf_wdata <= DATA_WIDTH'(reg_init_val(REG_INIT_MODE, 32'd0));
      end else if (reg_en) begin
        rf_wdata <= DATA_WIDTH'(reg_init_val(REG_INIT_MODE, 32'(rf_addr) + 32'd1));
      end

      if (accept) begin
        if (wrapped) begin
          overflow <= 1'b1;
        end else begin
          mem_we    <= 1'b1;
          mem_addr  <= MAW'({word_idx, 2'b00});
          mem_wdata <= load_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_cpu_boot_ctrl.sv
// Directed bench for cpu_boot_ctrl: one default instance (mode 1, 32 regs, 256 words)
// and one small instance (mode 0, 4 regs, 4 words) for the overflow path.
module tb_cpu_boot_ctrl;

  logic clock = 1'b0;
  logic rst_n = 1'b1;
  always #5 clock = ~clock;

  // Instance A: default geometry.
  logic        a_start, a_load_valid, a_load_ready, a_load_last;
  logic [31:0] a_load_data, a_mem_wdata, a_rf_wdata, a_cycle_count;
  logic        a_mem_we, a_rf_we, a_cpu_reset, a_busy, a_done, a_overflow;
  logic [9:0]  a_mem_addr;
  logic [4:0]  a_rf_addr;

  // Instance B: 4-word memory, 4 registers, all-zero init.
  logic        b_start, b_load_valid, b_load_ready, b_load_last;
  logic [31:0] b_load_data, b_mem_wdata, b_rf_wdata, b_cycle_count;
  logic        b_mem_we, b_rf_we, b_cpu_reset, b_busy, b_done, b_overflow;
  logic [3:0]  b_mem_addr;
  logic [1:0]  b_rf_addr;

  cpu_boot_ctrl #(
    .DATA_WIDTH(32), .ADDR_WIDTH(8), .REG_COUNT(32), .REG_INIT_MODE(1), .RUN_CYCLES(10)
  ) dut_a (
    .clock(clock), .reset(rst_n), .start(a_start),
    .load_valid(a_load_valid), .load_ready(a_load_ready), .load_data(a_load_data),
    .load_last(a_load_last), .mem_we(a_mem_we), .mem_addr(a_mem_addr),
    .mem_wdata(a_mem_wdata), .rf_we(a_rf_we), .rf_addr(a_rf_addr), .rf_wdata(a_rf_wdata),
    .cpu_reset(a_cpu_reset), .busy(a_busy), .done(a_done), .overflow(a_overflow),
    .cycle_count(a_cycle_count)
  );

  cpu_boot_ctrl #(
    .DATA_WIDTH(32), .ADDR_WIDTH(2), .REG_COUNT(4), .REG_INIT_MODE(0), .RUN_CYCLES(10)
  ) dut_b (
    .clock(clock), .reset(rst_n), .start(b_start),
    .load_valid(b_load_valid), .load_ready(b_load_ready), .load_data(b_load_data),
    .load_last(b_load_last), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
    .mem_wdata(b_mem_wdata), .rf_we(b_rf_we), .rf_addr(b_rf_addr), .rf_wdata(b_rf_wdata),
    .cpu_reset(b_cpu_reset), .busy(b_busy), .done(b_done), .overflow(b_overflow),
    .cycle_count(b_cycle_count)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic b_cpu_seen = 1'b0;

  always @(posedge clock) if (b_cpu_reset) b_cpu_seen <= 1'b1;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_idle_a(input string tag);
    check_eq({tag, ".load_ready"},  64'(a_load_ready),  64'd0);
    check_eq({tag, ".mem_we"},      64'(a_mem_we),      64'd0);
    check_eq({tag, ".mem_addr"},    64'(a_mem_addr),    64'd0);
    check_eq({tag, ".mem_wdata"},   64'(a_mem_wdata),   64'd0);
    check_eq({tag, ".rf_we"},       64'(a_rf_we),       64'd0);
    check_eq({tag, ".rf_addr"},     64'(a_rf_addr),     64'd0);
    check_eq({tag, ".rf_wdata"},    64'(a_rf_wdata),    64'd0);
    check_eq({tag, ".cpu_reset"},   64'(a_cpu_reset),   64'd0);
    check_eq({tag, ".busy"},        64'(a_busy),        64'd0);
    check_eq({tag, ".done"},        64'(a_done),        64'd0);
    check_eq({tag, ".overflow"},    64'(a_overflow),    64'd0);
    check_eq({tag, ".cycle_count"}, 64'(a_cycle_count), 64'd0);
  endtask

  initial begin
    int          run_len;
    int          guard;
    logic [31:0] d;

    a_start = 1'b0; a_load_valid = 1'b0; a_load_data = '0; a_load_last = 1'b0;
    b_start = 1'b0; b_load_valid = 1'b0; b_load_data = '0; b_load_last = 1'b0;

    // Reset asserted between edges, then released with no start.
    #2 rst_n = 1'b0;
    #1;
    check_idle_a("rst_async");
    check_eq("rst_async.b_done", 64'(b_done), 64'd0);
    tick(); tick();
    rst_n = 1'b1;
    tick(); tick();
    check_idle_a("post_rst");

    // Register-file init: 32 writes, value = index (r0 = 0); a stray start is ignored.
    a_start = 1'b1; tick(); a_start = 1'b0;
    for (int i = 0; i < 32; i++) begin
      check_eq("reg.rf_we",    64'(a_rf_we),    64'd1);
      check_eq("reg.rf_addr",  64'(a_rf_addr),  64'(i));
      check_eq("reg.rf_wdata", 64'(a_rf_wdata), 64'(i));
      a_start = (i == 10);
      tick();
    end
    a_start = 1'b0;
    check_eq("load_entry.rf_we",      64'(a_rf_we),      64'd0);
    check_eq("load_entry.load_ready", 64'(a_load_ready), 64'd1);
    check_eq("load_entry.busy",       64'(a_busy),       64'd1);
    check_eq("load_entry.cpu_reset",  64'(a_cpu_reset),  64'd0);

    tick();
    check_eq("load_idle.mem_we", 64'(a_mem_we), 64'd0);

    // Three-word image, back to back.
    a_load_valid = 1'b1; a_load_data = 32'h0000_0000; a_load_last = 1'b0;
    tick();
    check_eq("w0.mem_we",   64'(a_mem_we),    64'd1);
    check_eq("w0.mem_addr", 64'(a_mem_addr),  64'h0);
    check_eq("w0.wdata",    64'(a_mem_wdata), 64'h0);
    a_load_data = 32'h2010_0009;
    tick();
    check_eq("w1.mem_we",   64'(a_mem_we),    64'd1);
    check_eq("w1.mem_addr", 64'(a_mem_addr),  64'h4);
    check_eq("w1.wdata",    64'(a_mem_wdata), 64'h2010_0009);
    a_load_data = 32'h0000_0000; a_load_last = 1'b1;
    tick();
    check_eq("w2.mem_we",     64'(a_mem_we),     64'd1);
    check_eq("w2.mem_addr",   64'(a_mem_addr),   64'h8);
    check_eq("w2.wdata",      64'(a_mem_wdata),  64'h0);
    check_eq("w2.load_ready", 64'(a_load_ready), 64'd0);
    check_eq("w2.cpu_reset",  64'(a_cpu_reset),  64'd0);
    // Keep offering a word: it must not be taken after the last one.
    a_load_data = 32'hDEAD_BEEF; a_load_last = 1'b0;
    tick();
    a_load_valid = 1'b0;
    check_eq("run0.cpu_reset",   64'(a_cpu_reset),   64'd1);
    check_eq("run0.mem_we",      64'(a_mem_we),      64'd0);
    check_eq("run0.cycle_count", 64'(a_cycle_count), 64'd0);
    check_eq("run0.busy",        64'(a_busy),        64'd1);
    check_eq("run0.done",        64'(a_done),        64'd0);

`ifdef BOOT_WATCHDOG_EN
    run_len = 0;
    guard   = 0;
    while (a_cpu_reset === 1'b1 && guard < 50) begin
      run_len++;
      guard++;
      tick();
    end
    check_eq("wd.run_len",     64'(run_len),       64'd10);
    check_eq("wd.done",        64'(a_done),        64'd1);
    check_eq("wd.cycle_count", 64'(a_cycle_count), 64'd9);
    check_eq("wd.busy",        64'(a_busy),        64'd0);
`else
    run_len = 0;
    guard   = 0;
    for (int k = 0; k < 20; k++) tick();
    check_eq("run.cycle_count", 64'(a_cycle_count), 64'd20);
    check_eq("run.cpu_reset",   64'(a_cpu_reset),   64'd1);
    check_eq("run.done",        64'(a_done),        64'd0);
    a_start = 1'b1; tick(); a_start = 1'b0;
    check_eq("run_start.rf_we",       64'(a_rf_we),       64'd0);
    check_eq("run_start.cpu_reset",   64'(a_cpu_reset),   64'd1);
    check_eq("run_start.cycle_count", 64'(a_cycle_count), 64'd21);
`endif

    // Asynchronous reset from RUN/DONE, then a fresh boot into LOAD.
    #2 rst_n = 1'b0;
    #1;
    check_eq("rst_run.cpu_reset", 64'(a_cpu_reset), 64'd0);
    check_eq("rst_run.busy",      64'(a_busy),      64'd0);
    #2 rst_n = 1'b1;
    tick();
    a_start = 1'b1; tick(); a_start = 1'b0;
    repeat (32) tick();
    check_eq("reboot.load_ready", 64'(a_load_ready), 64'd1);
    a_load_valid = 1'b1; a_load_data = 32'h1234_5678; a_load_last = 1'b0;
    tick();
    check_eq("reboot.w0_addr", 64'(a_mem_addr), 64'h0);
    a_load_data = 32'hCAFE_0001;
    tick();
    a_load_valid = 1'b0;
    check_eq("reboot.w1_addr",  64'(a_mem_addr),  64'h4);
    check_eq("reboot.w1_wdata", 64'(a_mem_wdata), 64'hCAFE_0001);

    // Reset mid-LOAD: everything clears without a clock edge.
    #2 rst_n = 1'b0;
    #1;
    check_idle_a("rst_load");
    #2 rst_n = 1'b1;
    tick();
    check_idle_a("rst_load_rel");
    a_start = 1'b1; tick(); a_start = 1'b0;
    check_eq("restart.rf_we",       64'(a_rf_we),       64'd1);
    check_eq("restart.rf_addr",     64'(a_rf_addr),     64'd0);
    check_eq("restart.cycle_count", 64'(a_cycle_count), 64'd0);
    repeat (32) tick();
    a_load_valid = 1'b1; a_load_data = 32'h0BAD_F00D;
    tick();
    a_load_valid = 1'b0;
    check_eq("restart.w0_we",   64'(a_mem_we),   64'd1);
    check_eq("restart.w0_addr", 64'(a_mem_addr), 64'h0);

    // Instance B: mode 0 init then overflow on the fifth word.
    b_start = 1'b1; tick(); b_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check_eq("b_reg.rf_we",    64'(b_rf_we),    64'd1);
      check_eq("b_reg.rf_addr",  64'(b_rf_addr),  64'(i));
      check_eq("b_reg.rf_wdata", 64'(b_rf_wdata), 64'd0);
      tick();
    end
    check_eq("b_load.rf_we",      64'(b_rf_we),      64'd0);
    check_eq("b_load.load_ready", 64'(b_load_ready), 64'd1);
    b_load_valid = 1'b1;
    for (int w = 0; w < 5; w++) begin
      d = 32'h1111_1111 * 32'(w + 1);
      b_load_data = d;
      b_load_last = (w == 4);
      tick();
      if (w < 4) begin
        check_eq("b_w.mem_we",   64'(b_mem_we),    64'd1);
        check_eq("b_w.mem_addr", 64'(b_mem_addr),  64'(w * 4));
        check_eq("b_w.wdata",    64'(b_mem_wdata), 64'(d));
        check_eq("b_w.overflow", 64'(b_overflow),  64'd0);
      end else begin
        check_eq("b_ovf.mem_we",     64'(b_mem_we),     64'd0);
        check_eq("b_ovf.overflow",   64'(b_overflow),   64'd1);
        check_eq("b_ovf.done",       64'(b_done),       64'd1);
        check_eq("b_ovf.load_ready", 64'(b_load_ready), 64'd0);
        check_eq("b_ovf.busy",       64'(b_busy),       64'd0);
      end
    end
    b_load_valid = 1'b0; b_load_last = 1'b0;
    tick(); tick();
    check_eq("b_hold.done",      64'(b_done),      64'd1);
    check_eq("b_hold.overflow",  64'(b_overflow),  64'd1);
    check_eq("b_hold.cpu_reset", 64'(b_cpu_reset), 64'd0);

    // start from DONE clears overflow and the word index.
    b_start = 1'b1; tick(); b_start = 1'b0;
    check_eq("b_restart.overflow", 64'(b_overflow), 64'd0);
    check_eq("b_restart.done",     64'(b_done),     64'd0);
    check_eq("b_restart.rf_we",    64'(b_rf_we),    64'd1);
    check_eq("b_restart.rf_addr",  64'(b_rf_addr),  64'd0);
    repeat (4) tick();
    b_load_valid = 1'b1; b_load_data = 32'hABCD_0123;
    tick();
    b_load_valid = 1'b0;
    check_eq("b_restart.w0_we",   64'(b_mem_we),    64'd1);
    check_eq("b_restart.w0_addr", 64'(b_mem_addr),  64'h0);
    check_eq("b_restart.w0_data", 64'(b_mem_wdata), 64'hABCD_0123);
    check_eq("b_cpu_never_run",   64'(b_cpu_seen),  64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
